icache_assoc_controller: RTL
============================

ICACHE_ASSOC_CONTROLLER -- requirements
Module: icache_assoc_controller

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways (power of 2, 1..8); WAY_W = max(1, clog2(WAYS)).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, L2 words per line (power of 2, >=2); WIDX_W = clog2(WORDS_PER_LINE).
REQ-003 SHALL have parameter SETS, default 64, sets per way (power of 2, >=2); SET_W = clog2(SETS).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 pipe_req_valid  input  1  pipeline request present; held until fulfilled.
REQ-007 pipe_req_type  input  memory_operation_e  LOAD, STORE (treated as LOAD) or CLFLUSH.
REQ-008 pipe_flush_all  input  1  invalidate entire cache; held until pipe_flush_done.
REQ-009 pipe_req_fulfilled  output  1  one-cycle pulse, request complete.
REQ-010 pipe_flush_done  output  1  one-cycle pulse, flush-all complete.
REQ-011 way_hit  input  WAYS  per-way valid-and-tag-match for the indexed set.
REQ-012 way_valid  input  WAYS  per-way valid bits for the indexed set.
REQ-013 l2_req_valid  output  1  L2 read request outstanding.
REQ-014 l2_req_type  output  memory_operation_e  always LOAD.
REQ-015 l2_req_fulfilled  input  1  L2 returned one word this cycle.
REQ-016 fill_word_index  output  WIDX_W  word offset being requested/written.
REQ-017 fill_write  output  1  write returned word into fill_way at fill_word_index.
REQ-018 fill_way  output  WAY_W  victim way of current allocation.
REQ-019 install_line  output  1  set valid bit and tag of fill_way.
REQ-020 clear_valid  output  1  clear valid bit of clear_way in indexed set.
REQ-021 clear_way  output  WAY_W  way cleared by CLFLUSH.
REQ-022 flush_clear_all  output  1  clear valid bits of all ways in set flush_set_index.
REQ-023 flush_set_index  output  SET_W  set being cleared during flush-all.

Function
REQ-024 States SHALL be IDLE, ALLOCATE, FLUSH_ALL; undefined state drives all outputs and next state to X.
REQ-025 IDLE, pipe_flush_all=1: SHALL enter FLUSH_ALL, set counter 0; takes priority over pipe_req_valid.
REQ-026 IDLE, CLFLUSH, way_hit nonzero: SHALL pulse clear_valid and pipe_req_fulfilled same cycle, clear_way = index of set way_hit bit; stay IDLE.
REQ-027 IDLE, CLFLUSH, way_hit zero: SHALL pulse pipe_req_fulfilled only; stay IDLE.
REQ-028 IDLE, LOAD/STORE, way_hit nonzero: SHALL pulse pipe_req_fulfilled same cycle (zero-cycle hit latency); no other output.
REQ-029 IDLE, LOAD/STORE, way_hit zero: SHALL latch victim into fill_way, reset word counter to 0, enter ALLOCATE next cycle.
REQ-030 Victim SHALL be lowest-index way with way_valid=0; if all valid, round-robin pointer value, pointer then increments modulo WAYS.
REQ-031 Round-robin pointer SHALL advance only on all-valid misses; WAYS=1 always selects way 0.
REQ-032 ALLOCATE SHALL hold l2_req_valid=1, l2_req_type=LOAD, fill_word_index = word counter (Moore outputs).
REQ-033 ALLOCATE, l2_req_fulfilled=1: SHALL pulse fill_write, increment counter.
REQ-034 ALLOCATE, l2_req_fulfilled=1 with counter = WORDS_PER_LINE-1: SHALL also pulse install_line and return to IDLE next cycle; request is then re-evaluated as a hit.
REQ-035 ALLOCATE SHALL ignore pipe_flush_all and pipe_req_type changes until return to IDLE.
REQ-036 FLUSH_ALL SHALL assert flush_clear_all every cycle with flush_set_index = counter, counter incrementing by 1.
REQ-037 FLUSH_ALL at counter = SETS-1: SHALL pulse pipe_flush_done, reset round-robin pointer to 0, return to IDLE (SETS cycles total).
REQ-038 way_hit with more than one bit set is illegal; implementation SHALL assert $onehot0(way_hit) whenever sampled.

Reset
REQ-039 reset=1 at any edge, including mid-ALLOCATE or mid-FLUSH_ALL, SHALL force IDLE, word counter 0, flush counter 0, round-robin pointer 0.
REQ-040 In reset and IDLE without request, all 1-bit outputs SHALL be 0, index/way outputs 0, l2_req_type LOAD.

Verification
REQ-041 WAYS=2, WPL=4: LOAD, way_hit=00, way_valid=01 -> fill_way=1, 4 fill_write pulses at indices 0..3, install_line with 4th, then hit pulse.
REQ-042 way_valid=11 on three consecutive misses -> victims 0,1,0; pointer=1 afterwards.
REQ-043 CLFLUSH with way_hit=10 -> clear_valid=1, clear_way=1, pipe_req_fulfilled=1 same cycle.
REQ-044 l2_req_fulfilled gaps of 0-3 cycles between words -> fill_word_index holds, l2_req_valid stays 1, exactly WPL fill_write pulses.
REQ-045 pipe_flush_all, SETS=64 -> flush_clear_all for 64 cycles, indices 0..63, pipe_flush_done on 64th; simultaneous LOAD waits.
REQ-046 reset asserted after 2 fill words -> IDLE next cycle, all outputs 0; repeated miss restarts at index 0.

Source files
------------

// File: rtl/icache_assoc_controller.sv
// Set-associative instruction cache controller: zero-cycle hit handling,
// line allocation from L2 with victim selection (first invalid way, else
// round-robin), per-line CLFLUSH and whole-cache flush by set sweep.

package icache_assoc_controller_pkg;
   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      STORE   = 2'd1,
      CLFLUSH = 2'd2
   } memory_operation_e;
endpackage

module icache_assoc_controller
   import icache_assoc_controller_pkg::*;
#(
   parameter int WAYS           = 2,
   parameter int WORDS_PER_LINE = 4,
   parameter int SETS           = 64,
   parameter int WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1,
   parameter int WIDX_W         = $clog2(WORDS_PER_LINE),
   parameter int SET_W          = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_req_valid,
   input  memory_operation_e     pipe_req_type,
   input  logic                  pipe_flush_all,
   output logic                  pipe_req_fulfilled,
   output logic                  pipe_flush_done,
   input  logic [WAYS-1:0]       way_hit,
   input  logic [WAYS-1:0]       way_valid,
   output logic                  l2_req_valid,
   output memory_operation_e     l2_req_type,
   input  logic                  l2_req_fulfilled,
   output logic [WIDX_W-1:0]     fill_word_index,
   output logic                  fill_write,
   output logic [WAY_W-1:0]      fill_way,
   output logic                  install_line,
   output logic                  clear_valid,
   output logic [WAY_W-1:0]      clear_way,
   output logic                  flush_clear_all,
   output logic [SET_W-1:0]      flush_set_index
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ALLOCATE  = 2'd1;
   localparam logic [1:0] FLUSH_ALL = 2'd2;

   logic [1:0]        state_reg, state_next;
   logic [WIDX_W-1:0] word_cnt_reg, word_cnt_next;
   logic [SET_W-1:0]  flush_cnt_reg, flush_cnt_next;
   logic [WAY_W-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [WAY_W-1:0]  fill_way_reg, fill_way_next;

   logic              any_hit;
   logic              all_valid;
   logic              is_clflush;
   logic              last_word;
   logic              last_set;
   logic [WAY_W-1:0]  hit_idx;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  rr_inc;
   logic [WAY_W-1:0]  hit_term [WAYS];

   assign any_hit    = |way_hit;
   assign all_valid  = &way_valid;
   assign is_clflush = (pipe_req_type == CLFLUSH);
   assign last_word  = (word_cnt_reg == WIDX_W'(WORDS_PER_LINE - 1));
   assign last_set   = (flush_cnt_reg == SET_W'(SETS - 1));
   // A single-way cache has nothing to rotate; otherwise the pointer wraps naturally.
   assign rr_inc     = (WAYS == 1) ? '0 : rr_ptr_reg + 1'b1;

   // Each way contributes its own index when it hits; one-hot input makes the OR an encoder.
   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
         assign hit_term[gi] = way_hit[gi] ? WAY_W'(gi) : '0;
      end
   endgenerate

   // Combine per-way hit terms into the hit way index.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < WAYS; i++) begin
         hit_idx = hit_idx | hit_term[i];
      end
   end

   // Victim choice: lowest invalid way, falling back to the round-robin pointer.
   always_comb begin
      logic found;
      found  = 1'b0;
      victim = rr_ptr_reg;
      for (int i = 0; i < WAYS; i++) begin
         if (!found && !way_valid[i]) begin
            victim = WAY_W'(i);
            found  = 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         word_cnt_reg  <= '0;
         flush_cnt_reg <= '0;
         rr_ptr_reg    <= '0;
         fill_way_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         word_cnt_reg  <= word_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         rr_ptr_reg    <= rr_ptr_next;
         fill_way_reg  <= fill_way_next;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_next     = state_reg;
      word_cnt_next  = word_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      rr_ptr_next    = rr_ptr_reg;
      fill_way_next  = fill_way_reg;
      case (state_reg)
         IDLE: begin
            if (pipe_flush_all) begin
               state_next     = FLUSH_ALL;
               flush_cnt_next = '0;
            end else if (pipe_req_valid && !is_clflush && !any_hit) begin
               state_next    = ALLOCATE;
               word_cnt_next = '0;
               fill_way_next = victim;
               // Only evicting a valid line rotates the replacement pointer.
               if (all_valid) begin
                  rr_ptr_next = rr_inc;
               end
            end
         end
         ALLOCATE: begin
            if (l2_req_fulfilled) begin
               word_cnt_next = word_cnt_reg + 1'b1;
               if (last_word) begin
                  state_next = IDLE;
               end
            end
         end
         FLUSH_ALL: begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
            if (last_set) begin
               state_next  = IDLE;
               rr_ptr_next = '0;
            end
         end
         default: begin
            state_next     = 'x;
            word_cnt_next  = 'x;
            flush_cnt_next = 'x;
            rr_ptr_next    = 'x;
            fill_way_next  = 'x;
         end
      endcase
   end

   // Output decode: IDLE outputs are Mealy (zero-cycle hits), the rest Moore plus fill strobes.
   always_comb begin
      pipe_req_fulfilled = 1'b0;
      pipe_flush_done    = 1'b0;
      l2_req_valid       = 1'b0;
      l2_req_type        = LOAD;
      fill_word_index    = '0;
      fill_write         = 1'b0;
      fill_way           = '0;
      install_line       = 1'b0;
      clear_valid        = 1'b0;
      clear_way          = '0;
      flush_clear_all    = 1'b0;
      flush_set_index    = '0;
      case (state_reg)
         IDLE: begin
            if (!pipe_flush_all && pipe_req_valid) begin
               if (is_clflush) begin
                  pipe_req_fulfilled = 1'b1;
                  if (any_hit) begin
                     clear_valid = 1'b1;
                     clear_way   = hit_idx;
                  end
               end else if (any_hit) begin
                  pipe_req_fulfilled = 1'b1;
               end
            end
         end
         ALLOCATE: begin
            l2_req_valid    = 1'b1;
            fill_word_index = word_cnt_reg;
            fill_way        = fill_way_reg;
            fill_write      = l2_req_fulfilled;
            install_line    = l2_req_fulfilled && last_word;
         end
         FLUSH_ALL: begin
            flush_clear_all = 1'b1;
            flush_set_index = flush_cnt_reg;
            pipe_flush_done = last_set;
         end
         default: begin
            pipe_req_fulfilled = 1'bx;
            pipe_flush_done    = 1'bx;
            l2_req_valid       = 1'bx;
            l2_req_type        = memory_operation_e'(2'bxx);
            fill_word_index    = 'x;
            fill_write         = 1'bx;
            fill_way           = 'x;
            install_line       = 1'bx;
            clear_valid        = 1'bx;
            clear_way          = 'x;
            flush_clear_all    = 1'bx;
            flush_set_index    = 'x;
         end
      endcase
   end

   // Two ways matching the same tag means corrupted tag state; flag it wherever hits are used.
   assert property (@(posedge clk) disable iff (reset)
      (state_reg == IDLE && pipe_req_valid) |-> $onehot0(way_hit));

endmodule
